// File: rtl/issue_execute_fifo_pkg.sv
// Shared types and sizing constants for the issue-to-execute path.
package issue_execute_fifo_pkg;

    localparam int unsigned ALU_UNIT_NUM         = 2;
    localparam int unsigned ISSUE_ALU_FIFO_DEPTH = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  rob_id;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
    } issue_execute_pack_t;

endpackage

// File: rtl/issue_execute_fifo_ptr.sv
// Wrap-bit FIFO pointer: low bits index storage, MSB toggles on each wrap.
module issue_execute_fifo_ptr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W:0]   ptr_o
);

    logic [W:0] ptr_q;
    logic [W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + {{W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/issue_execute_fifo.sv
// Circular buffer of issue_execute_pack_t between issue and one execute unit.
module issue_execute_fifo
    import issue_execute_fifo_pkg::*;
#(
    parameter int unsigned DEPTH       = ISSUE_ALU_FIFO_DEPTH,
    localparam int unsigned DEPTH_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  issue_execute_pack_t       issue_alu_fifo_data_in,
    input  logic                      issue_alu_fifo_push,
    output logic                      issue_alu_fifo_full,
    output issue_execute_pack_t       issue_alu_fifo_data_out,
    output logic                      issue_alu_fifo_data_out_valid,
    input  logic                      issue_alu_fifo_pop,
    input  logic                      issue_alu_fifo_flush,
    output logic [DEPTH_WIDTH:0]      issue_alu_fifo_count
);

    logic [DEPTH_WIDTH:0] rptr;
    logic [DEPTH_WIDTH:0] wptr;
    logic                 empty;
    logic                 push_ok;
    logic                 pop_ok;

    issue_execute_pack_t  mem_q [DEPTH];

    assign empty   = (rptr == wptr);
    assign issue_alu_fifo_full = (rptr[DEPTH_WIDTH-1:0] == wptr[DEPTH_WIDTH-1:0]) &&
                                 (rptr[DEPTH_WIDTH] != wptr[DEPTH_WIDTH]);
    assign issue_alu_fifo_data_out_valid = !empty;
    assign issue_alu_fifo_count = wptr - rptr;

    // Flush wins over both handshakes so a flushed cycle leaves no trace.
    assign push_ok = issue_alu_fifo_push && !issue_alu_fifo_full && !issue_alu_fifo_flush;
    assign pop_ok  = issue_alu_fifo_pop && !empty && !issue_alu_fifo_flush;

    issue_execute_fifo_ptr #(.W(DEPTH_WIDTH)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_ok),
        .clr_i (issue_alu_fifo_flush),
        .ptr_o (rptr)
    );

    issue_execute_fifo_ptr #(.W(DEPTH_WIDTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_ok),
        .clr_i (issue_alu_fifo_flush),
        .ptr_o (wptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr[DEPTH_WIDTH-1:0]] <= issue_alu_fifo_data_in;
        end
    end

    // Gate the head with empty so stale storage is never visible.
    always_comb begin
        issue_alu_fifo_data_out = '0;
        if (!empty) begin
            issue_alu_fifo_data_out = mem_q[rptr[DEPTH_WIDTH-1:0]];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(issue_alu_fifo_count) <= int'(DEPTH));
            assert (!(issue_alu_fifo_full && !issue_alu_fifo_data_out_valid));
        end
    end
`endif

endmodule

// File: doc/issue_execute_fifo.md
Name: issue_execute_fifo

Overview:
Circular buffer between the issue stage and one execute unit (ALU instance), carrying issue_execute_pack_t entries.
- Issue side pushes.
- Execute side pops via the data_out/data_out_valid/pop handshake that execute_alu consumes.
- Commit-side flush empties it.
- One instance per ALU_UNIT_NUM lane; also reusable for other execute units.

Parameters:
DEPTH, 4, number of entries; must be a power of two, at least 2.
DEPTH_WIDTH, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
issue_alu_fifo_data_in  input  issue_execute_pack_t  entry to enqueue
issue_alu_fifo_push  input  1  enqueue request
issue_alu_fifo_full  output  1  no free entry
issue_alu_fifo_data_out  output  issue_execute_pack_t  head entry
issue_alu_fifo_data_out_valid  output  1  head entry present
issue_alu_fifo_pop  input  1  dequeue request from execute unit
issue_alu_fifo_flush  input  1  discard all entries (commit flush)
issue_alu_fifo_count  output  DEPTH_WIDTH+1  occupied entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset: rptr=0, wptr=0 (each DEPTH_WIDTH+1 bits including wrap bit).
  - Outputs: full=0, data_out_valid=0, data_out=all-zero, count=0.
  - Storage array is not reset.
- Pointers: index = low DEPTH_WIDTH bits; the MSB is the wrap bit.
  - empty = (rptr == wptr).
  - full = index equal AND wrap bits differ.
  - count = wptr - rptr, modulo 2^(DEPTH_WIDTH+1).
- Outputs are combinational from registered pointers only; no input-to-output combinational path.
  - data_out = storage[rptr index] when non-empty, else all-zero.
  - data_out_valid = !empty.
- Push accepted iff push=1, full=0, flush=0.
  - Entry written at wptr; wptr+1 at the edge.
  - Push while full is dropped silently; state unchanged.
- Pop accepted iff pop=1, data_out_valid=1, flush=0.
  - rptr+1 at the edge. Pop while empty is ignored.
- Simultaneous push and pop, both accepted: count unchanged, both pointers advance.
- Full with push+pop: pop accepted, push dropped. full does not depend on same-cycle pop.
- Empty with push+pop: push accepted, pop ignored.
  - No fall-through; the entry is first visible the following cycle.
- Latency: entry pushed at edge N is on data_out, valid=1, after edge N if the FIFO was empty.
- Flush overrides push and pop.
  - At the next edge: rptr=wptr=0, count=0, valid=0.
  - The pushed entry in that cycle is discarded.
- Wrap-around: index wraps DEPTH-1 -> 0 and toggles the wrap bit. Order is preserved across the wrap.
- Reset asserted mid-operation: immediate (asynchronous) return to reset values; all contents lost.
- Storage contents are never inspected beyond the head; stale data is never exposed while empty.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - full and data_out_valid=0 are never both true.

Decomposition:
- issue_execute_pack_t stays in the shared common package.
- DEPTH default constant (ISSUE_ALU_FIFO_DEPTH) goes in config.svh alongside ALU_UNIT_NUM.
- Natural sub-module: fifo_ptr (wrap-bit pointer with increment and clear), instantiated twice for rptr and wptr.
- Storage is a plain register array inside issue_execute_fifo.

Test Plan:
- Reset, then push pc=0x80000000, rob_id=1 for one cycle -> next cycle data_out_valid=1, data_out.pc=0x80000000, count=1, full=0.
- Push 4 entries, rob_id=1..4, DEPTH=4 -> full=1, count=4. Fifth push rob_id=5 is dropped. Pop 4 times -> rob_id 1,2,3,4 in order, then valid=0.
- Steady stream with push+pop every cycle for 10 cycles, rob_id incrementing -> count constant at 1, pointers wrap twice, output order matches input order.
- FIFO holding 3 entries, flush=1 with push=1 and pop=1 in the same cycle -> next cycle count=0, valid=0, data_out=0; the pushed entry never appears.
- Empty FIFO, push+pop same cycle -> pop ignored, count=1 next cycle. Full FIFO, push+pop -> count=3 next cycle, head advances by one.
- Assert rst asynchronously between edges with 2 entries held -> valid=0 and count=0 immediately, before the next clk edge.
